// File: rtl/cpu_defs.sv
// Shared opcode, control-bit and control-mask definitions for the
// microcoded sequencer and its decode ROM.
package cpu_defs;

    localparam int CTRL_W = 16;

    localparam int OP_NOP = 0;
    localparam int OP_LDA = 1;
    localparam int OP_ADD = 2;
    localparam int OP_SUB = 3;
    localparam int OP_STA = 4;
    localparam int OP_LDI = 5;
    localparam int OP_JMP = 6;
    localparam int OP_JC  = 7;
    localparam int OP_JZ  = 8;
    localparam int OP_OUT = 14;
    localparam int OP_HLT = 15;

    localparam int B_HLT = 15;
    localparam int B_MI  = 14;
    localparam int B_RI  = 13;
    localparam int B_RO  = 12;
    localparam int B_IO  = 11;
    localparam int B_II  = 10;
    localparam int B_AI  = 9;
    localparam int B_AO  = 8;
    localparam int B_EO  = 7;
    localparam int B_SU  = 6;
    localparam int B_BI  = 5;
    localparam int B_OI  = 4;
    localparam int B_CE  = 3;
    localparam int B_CO  = 2;
    localparam int B_J   = 1;
    localparam int B_FI  = 0;

    typedef logic [CTRL_W-1:0] ctrl_t;

    localparam ctrl_t M_HLT = ctrl_t'(1) << B_HLT;
    localparam ctrl_t M_MI  = ctrl_t'(1) << B_MI;
    localparam ctrl_t M_RI  = ctrl_t'(1) << B_RI;
    localparam ctrl_t M_RO  = ctrl_t'(1) << B_RO;
    localparam ctrl_t M_IO  = ctrl_t'(1) << B_IO;
    localparam ctrl_t M_II  = ctrl_t'(1) << B_II;
    localparam ctrl_t M_AI  = ctrl_t'(1) << B_AI;
    localparam ctrl_t M_AO  = ctrl_t'(1) << B_AO;
    localparam ctrl_t M_EO  = ctrl_t'(1) << B_EO;
    localparam ctrl_t M_SU  = ctrl_t'(1) << B_SU;
    localparam ctrl_t M_BI  = ctrl_t'(1) << B_BI;
    localparam ctrl_t M_OI  = ctrl_t'(1) << B_OI;
    localparam ctrl_t M_CE  = ctrl_t'(1) << B_CE;
    localparam ctrl_t M_CO  = ctrl_t'(1) << B_CO;
    localparam ctrl_t M_J   = ctrl_t'(1) << B_J;
    localparam ctrl_t M_FI  = ctrl_t'(1) << B_FI;

endpackage

// File: rtl/microcode_rom.sv
// Combinational microcode decode: opcode, microstep and flags in,
// control word out. Unlisted opcode/step pairs decode to all-zero.
module microcode_rom
    import cpu_defs::*;
#(
    parameter int OPCODE_W = 4,
    parameter int STEP_W   = 3
) (
    input  logic [OPCODE_W-1:0] opcode_i,
    input  logic [STEP_W-1:0]   step_i,
    input  logic                carry_i,
    input  logic                zero_i,
    output logic [CTRL_W-1:0]   ctrl_o
);

    int op;
    int s;

    always_comb begin
        op     = int'(opcode_i);
        s      = int'(step_i);
        ctrl_o = '0;
        if (s == 0) begin
            ctrl_o = M_CO | M_MI;
        end else if (s == 1) begin
            ctrl_o = M_RO | M_II | M_CE;
        end else begin
            case (op)
                OP_LDA: begin
                    if (s == 2) ctrl_o = M_IO | M_MI;
                    if (s == 3) ctrl_o = M_RO | M_AI;
                end
                OP_ADD, OP_SUB: begin
                    if (s == 2) ctrl_o = M_IO | M_MI;
                    if (s == 3) ctrl_o = M_RO | M_BI;
                    if (s == 4) begin
                        ctrl_o = M_EO | M_AI | M_FI;
                        if (op == OP_SUB) ctrl_o = ctrl_o | M_SU;
                    end
                end
                OP_STA: begin
                    if (s == 2) ctrl_o = M_IO | M_MI;
                    if (s == 3) ctrl_o = M_AO | M_RI;
                end
                OP_LDI: if (s == 2) ctrl_o = M_IO | M_AI;
                OP_JMP: if (s == 2) ctrl_o = M_IO | M_J;
                // Conditional jumps collapse to an empty step when not taken
                OP_JC:  if (s == 2 && carry_i) ctrl_o = M_IO | M_J;
                OP_JZ:  if (s == 2 && zero_i) ctrl_o = M_IO | M_J;
                OP_OUT: if (s == 2) ctrl_o = M_AO | M_OI;
                OP_HLT: if (s == 2) ctrl_o = M_HLT;
                default: ctrl_o = '0;
            endcase
        end
    end

endmodule

// File: rtl/control_sequencer.sv
// Microcoded control sequencer: instruction register, microstep counter,
// ALU flags, halt latch and single-step edge detection.
module control_sequencer
    import cpu_defs::*;
#(
    parameter int  DATA_WIDTH = 8,
    parameter int  OPCODE_W   = 4,
    parameter int  STEP_COUNT = 5,
    localparam int STEP_W     = $clog2(STEP_COUNT)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run_en,
    input  logic                  step_req,
    input  logic [DATA_WIDTH-1:0] bus_in,
    input  logic                  carry_in,
    input  logic                  zero_in,
    output logic [CTRL_W-1:0]     ctrl,
    output logic [DATA_WIDTH-1:0] ir_bus_out,
    output logic                  ir_bus_oe,
    output logic [STEP_W-1:0]     step,
    output logic                  halted
);

    localparam int OPER_W = DATA_WIDTH - OPCODE_W;
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEP_COUNT - 1);
    localparam logic [STEP_W-1:0] BODY_STEP = STEP_W'(2);

    logic [DATA_WIDTH-1:0] ir_q, ir_d;
    logic [STEP_W-1:0]     step_q, step_d;
    logic                  carry_q, carry_d;
    logic                  zero_q, zero_d;
    logic                  halted_q, halted_d;
    logic                  step_req_q;
    logic                  step_rise;
    logic                  advance;

    microcode_rom #(
        .OPCODE_W (OPCODE_W),
        .STEP_W   (STEP_W)
    ) u_rom (
        .opcode_i (ir_q[DATA_WIDTH-1 -: OPCODE_W]),
        .step_i   (step_q),
        .carry_i  (carry_q),
        .zero_i   (zero_q),
        .ctrl_o   (ctrl)
    );

    // A held step_req yields one advance; run mode swallows any edge
    assign step_rise = step_req & ~step_req_q;
    assign advance   = ~halted_q & (run_en | step_rise);

    always_comb begin
        ir_d     = ir_q;
        step_d   = step_q;
        carry_d  = carry_q;
        zero_d   = zero_q;
        halted_d = halted_q;
        if (advance) begin
            if (ctrl[B_HLT]) begin
                halted_d = 1'b1;
            end else begin
                if (ctrl[B_II]) ir_d = bus_in;
                if (ctrl[B_FI]) begin
                    carry_d = carry_in;
                    zero_d  = zero_in;
                end
                if (step_q == LAST_STEP ||
                    (step_q >= BODY_STEP && ctrl == '0)) begin
                    step_d = '0;
                end else begin
                    step_d = step_q + STEP_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir_q       <= '0;
            step_q     <= '0;
            carry_q    <= 1'b0;
            zero_q     <= 1'b0;
            halted_q   <= 1'b0;
            step_req_q <= 1'b0;
        end else begin
            ir_q       <= ir_d;
            step_q     <= step_d;
            carry_q    <= carry_d;
            zero_q     <= zero_d;
            halted_q   <= halted_d;
            step_req_q <= step_req;
        end
    end

    assign ir_bus_out = {{OPCODE_W{1'b0}}, ir_q[OPER_W-1:0]};
    assign ir_bus_oe  = ctrl[B_IO];
    assign step       = step_q;
    assign halted     = halted_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: each instruction is modelled
// as a list of control words, checked once per cycle by a monitor.
module tb_control_sequencer;

    localparam logic [15:0] C_HLT = 16'h8000;
    localparam logic [15:0] C_MI  = 16'h4000;
    localparam logic [15:0] C_RI  = 16'h2000;
    localparam logic [15:0] C_RO  = 16'h1000;
    localparam logic [15:0] C_IO  = 16'h0800;
    localparam logic [15:0] C_II  = 16'h0400;
    localparam logic [15:0] C_AI  = 16'h0200;
    localparam logic [15:0] C_AO  = 16'h0100;
    localparam logic [15:0] C_EO  = 16'h0080;
    localparam logic [15:0] C_SU  = 16'h0040;
    localparam logic [15:0] C_BI  = 16'h0020;
    localparam logic [15:0] C_OI  = 16'h0010;
    localparam logic [15:0] C_CE  = 16'h0008;
    localparam logic [15:0] C_CO  = 16'h0004;
    localparam logic [15:0] C_J   = 16'h0002;
    localparam logic [15:0] C_FI  = 16'h0001;
    localparam int NSTEPS = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        run_en = 1'b0;
    logic        step_req = 1'b0;
    logic [7:0]  bus_in = 8'h00;
    logic        carry_in = 1'b0;
    logic        zero_in = 1'b0;
    logic [15:0] ctrl;
    logic [7:0]  ir_bus_out;
    logic        ir_bus_oe;
    logic [2:0]  step;
    logic        halted;

    always #5 clk = ~clk;

    control_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .run_en     (run_en),
        .step_req   (step_req),
        .bus_in     (bus_in),
        .carry_in   (carry_in),
        .zero_in    (zero_in),
        .ctrl       (ctrl),
        .ir_bus_out (ir_bus_out),
        .ir_bus_oe  (ir_bus_oe),
        .step       (step),
        .halted     (halted)
    );

    typedef struct packed {
        logic [15:0] ctrl;
        logic [2:0]  step;
        logic        halted;
        logic [7:0]  irout;
        logic        oe;
    } exp_t;

    typedef logic [15:0] wq_t [$];

    exp_t sbq [$];
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [7:0] m_ir;
    int         m_step;
    bit         m_c, m_z, m_halt, m_prev;

    // Whole instruction as the ordered list of its control words
    function automatic wq_t program_of(input logic [7:0] ir,
                                       input bit c, input bit z);
        wq_t p;
        p.push_back(C_CO | C_MI);
        p.push_back(C_RO | C_II | C_CE);
        case (ir[7:4])
            4'd1: begin
                p.push_back(C_IO | C_MI);
                p.push_back(C_RO | C_AI);
            end
            4'd2, 4'd3: begin
                p.push_back(C_IO | C_MI);
                p.push_back(C_RO | C_BI);
                p.push_back(C_EO | C_AI | C_FI |
                            ((ir[7:4] == 4'd3) ? C_SU : 16'h0));
            end
            4'd4: begin
                p.push_back(C_IO | C_MI);
                p.push_back(C_AO | C_RI);
            end
            4'd5:  p.push_back(C_IO | C_AI);
            4'd6:  p.push_back(C_IO | C_J);
            4'd7:  if (c) p.push_back(C_IO | C_J);
            4'd8:  if (z) p.push_back(C_IO | C_J);
            4'd14: p.push_back(C_AO | C_OI);
            4'd15: p.push_back(C_HLT);
            default: ;
        endcase
        return p;
    endfunction

    function automatic logic [15:0] word_at(input wq_t p, input int s);
        return (s < p.size()) ? p[s] : 16'h0000;
    endfunction

    function automatic exp_t expected();
        exp_t e;
        wq_t  p;
        p        = program_of(m_ir, m_c, m_z);
        e.ctrl   = word_at(p, m_step);
        e.step   = 3'(m_step);
        e.halted = m_halt;
        e.irout  = {4'h0, m_ir[3:0]};
        e.oe     = e.ctrl[11];
        return e;
    endfunction

    task automatic model_clock(input bit run, input bit sreq,
                               input logic [7:0] bus,
                               input bit c, input bit z);
        bit          adv;
        wq_t         p;
        logic [15:0] w;
        adv    = !m_halt && (run || (sreq && !m_prev));
        m_prev = sreq;
        if (adv) begin
            p = program_of(m_ir, m_c, m_z);
            w = word_at(p, m_step);
            if (w == C_HLT) begin
                m_halt = 1'b1;
            end else begin
                if ((w & C_II) != 0) m_ir = bus;
                if ((w & C_FI) != 0) begin
                    m_c = c;
                    m_z = z;
                end
                if (m_step >= p.size() || m_step == NSTEPS - 1)
                    m_step = 0;
                else
                    m_step = m_step + 1;
            end
        end
    endtask

    task automatic model_reset();
        m_ir   = 8'h00;
        m_step = 0;
        m_c    = 1'b0;
        m_z    = 1'b0;
        m_halt = 1'b0;
        m_prev = 1'b0;
    endtask

    // Entered and left at 1 time unit after a falling edge
    task automatic cycle(input bit run, input bit sreq,
                         input logic [7:0] bus,
                         input bit c, input bit z);
        run_en   = run;
        step_req = sreq;
        bus_in   = bus;
        carry_in = c;
        zero_in  = z;
        model_clock(run, sreq, bus, c, z);
        sbq.push_back(expected());
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        n_tests++;
        if (ctrl !== 16'h4004 || step !== 3'd0 || halted !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset got ctrl=%h step=%0d halted=%b want ctrl=4004 step=0 halted=0",
                     ctrl, step, halted);
        end
        model_reset();
        sbq.push_back(expected());
        @(negedge clk);
        #1;
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        exp_t a;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            a = {ctrl, step, halted, ir_bus_out, ir_bus_oe};
            n_tests++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL scoreboard t=%0t got ctrl=%h step=%0d halted=%b ir_out=%h oe=%b want ctrl=%h step=%0d halted=%b ir_out=%h oe=%b",
                         $time, a.ctrl, a.step, a.halted, a.irout, a.oe,
                         e.ctrl, e.step, e.halted, e.irout, e.oe);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        @(negedge clk);
        #1;

        // LDI 0x57 loops: IO|AI at step 2, back to 0 after 4 advances
        do_reset();
        repeat (9) cycle(1, 0, 8'h57, 0, 0);

        // ADD latches carry=1 zero=0, JC taken, JZ not taken
        do_reset();
        repeat (5) cycle(1, 0, 8'h2A, 1, 0);
        repeat (4) cycle(1, 0, 8'h73, 0, 1);
        repeat (4) cycle(1, 0, 8'h83, 0, 1);

        // Reset abandons an instruction sitting at step 3
        do_reset();
        repeat (3) cycle(1, 0, 8'h3C, 1, 1);
        do_reset();

        // Step mode: held request is one advance, then three pulses
        repeat (10) cycle(0, 1, 8'h57, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 8'h57, 0, 0);
            cycle(0, 1, 8'h57, 0, 0);
        end
        // Edge coinciding with run mode advances only once
        cycle(0, 0, 8'h57, 0, 0);
        cycle(1, 1, 8'h57, 0, 0);
        repeat (3) cycle(0, 1, 8'h57, 0, 0);

        // Halt sticks through clocks and pulses until reset
        do_reset();
        repeat (6) cycle(1, 0, 8'hF0, 1, 1);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 1, 8'h00, 0, 0);
            cycle(0, 0, 8'h00, 0, 0);
        end
        do_reset();

        // Undefined opcode behaves as NOP
        repeat (6) cycle(1, 0, 8'hA0, 0, 0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            if (m_halt ? ($urandom_range(0, 3) == 0)
                       : ($urandom_range(0, 79) == 0))
                do_reset();
            cycle(($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 1)),
                  8'($urandom),
                  1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)));
        end

        @(negedge clk);
        #1;
        n_tests++;
        if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain got %0d pending want 0", sbq.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, bus and instruction-register width.
REQ-002 SHALL have parameter OPCODE_W, default 4, opcode width; the opcode is IR[DATA_WIDTH-1 -: OPCODE_W] and the operand is the remaining low bits.
REQ-003 SHALL have parameter STEP_COUNT, default 5, microsteps per instruction (minimum 3); STEP_W = clog2(STEP_COUNT).
REQ-004 SHALL have port clk, input, 1, single system clock.
REQ-005 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-006 SHALL have port run_en, input, 1: 1 = free-run every clk; 0 = single-step mode.
REQ-007 SHALL have port step_req, input, 1: in step mode, advance one microstep on a rising edge of step_req.
REQ-008 SHALL have port bus_in, input, DATA_WIDTH: main bus value sampled by the IR.
REQ-009 SHALL have ports carry_in and zero_in, input, 1 each: ALU flag sources.
REQ-010 SHALL have port ctrl, output, 16: control word, bit order HLT MI RI RO IO II AI AO EO SU BI OI CE CO J FI (bit15..bit0).
REQ-011 SHALL have port ir_bus_out, output, DATA_WIDTH: zero-extended operand.
REQ-012 SHALL have port ir_bus_oe, output, 1: equals ctrl.IO; the tri-state driver sits at top level.
REQ-013 SHALL have port step, output, STEP_W: current microstep.
REQ-014 SHALL have port halted, output, 1: halt state indicator.

Function
REQ-015 SHALL make ctrl a combinational decode of {opcode, step, flags} from registered state, with no combinational path from bus_in.
REQ-016 SHALL define an advance event as: run_en=1, or (run_en=0 and step_req rose since the previous clk, detected on a registered copy of step_req); no advance occurs while halted.
REQ-017 SHALL, on each advance, load the IR from bus_in when II=1, load the flags from carry_in/zero_in when FI=1, and then update step.
REQ-018 SHALL decode step 0 as CO|MI and step 1 as RO|II|CE for every opcode.
REQ-019 SHALL decode the opcodes as follows:
- NOP=0
- LDA=1: IO|MI, RO|AI
- ADD=2: IO|MI, RO|BI, EO|AI|FI
- SUB=3: as ADD, plus SU in the last step
- STA=4: IO|MI, AO|RI
- LDI=5: IO|AI
- JMP=6: IO|J
- JC=7: IO|J when carry_flag=1, else 0
- JZ=8: as JC using zero_flag
- OUT=14: AO|OI
- HLT=15: HLT
- undefined opcodes: as NOP
REQ-020 SHALL set step to 0 on the advance of a step at or above 2 whose decoded word is all-zero, and likewise after step STEP_COUNT-1 (wrap-around); this gives early termination, so NOP takes 3 advances.
REQ-021 SHALL, on an advance while HLT=1, set halted=1 and freeze step, IR and flags; ctrl keeps presenting HLT until reset.
REQ-022 SHALL accept a run_en change at any cycle, effective from the next clk.
REQ-023 SHALL ignore a step_req edge that coincides with run_en=1 (no double advance).
REQ-024 SHALL, when OPCODE_W=4 and DATA_WIDTH>8, zero-extend the operand to DATA_WIDTH.

Reset
REQ-025 SHALL, on rst=1 (asynchronous), clear IR, step, carry_flag, zero_flag, halted and the step_req history register to 0, which gives ctrl = CO|MI.
REQ-026 SHALL, when reset is asserted mid-instruction, abandon that instruction; the first advance after release executes fetch step 0.

Structure
REQ-027 SHALL place the opcode constants, control-bit index constants and the CTRL_W=16 constant in a shared package, cpu_defs.
REQ-028 SHALL implement the microcode decode as the sub-module microcode_rom (pure combinational: opcode, step, flags -> ctrl).
REQ-029 SHALL keep the sequencer registers (IR, step, flags, halted, edge detect) in control_sequencer.

Verification
REQ-030 SHALL verify reset: assert rst mid-step 3 -> step=0, ctrl=0x4004 (CO|MI) immediately, halted=0.
REQ-031 SHALL verify LDI: run_en=1, bus_in=0x57 during step 1 -> IR=0x57; step 2 ctrl=IO|AI, ir_bus_out=0x07; step returns to 0 after 4 advances.
REQ-032 SHALL verify ADD and flags: carry_in=1, zero_in=0 at step 4 -> flags latch; a following JC 0x3 gives IO|J at step 2; JZ gives 0 with early return to step 0.
REQ-033 SHALL verify step mode: run_en=0 with step_req held high for 10 clks -> exactly one advance; 3 separate pulses -> 3 advances.
REQ-034 SHALL verify halt: IR=0xF0 -> halted=1 after the step-2 advance; further clks and step_req pulses leave step=2; only rst clears it.
REQ-035 SHALL verify an undefined opcode: IR=0xA0 -> ctrl=0 at step 2 and step returns to 0 on the next advance.
